dec_scan_n: RTL
===============

Name: dec_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with a built-in auto-scan sequencer.
- Successor to the fixed 4-to-16 combinational decoder. Drives multiplexed display digit enables, bank selects and row strobes.
- Supports two modes:
  - DIRECT: decodes a latched address.
  - SCAN: steps through all outputs at a prescaled rate.

Parameters:
- ADDR_W, 4, address width in bits; legal range 1..6.
- OUT_W, 16, number of decoded outputs; legal range 2..2**ADDR_W.
- PRESCALE, 16, CLK cycles per scan step; minimum 1.
- ACTIVE_LOW, 0, 1 inverts every DEC bit (selected output = 0, all others = 1).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  synchronous reset, active-low.
- EN  input  1  1 = block operates; 0 = outputs go inactive and counters hold.
- MODE  input  1  0 = DIRECT, 1 = SCAN; sampled every cycle.
- LOAD  input  1  single-cycle strobe; latches ADDR in DIRECT mode.
- ADDR  input  ADDR_W  address to decode.
- DEC  output  OUT_W  registered one-hot select (polarity set by ACTIVE_LOW).
- CUR_ADDR  output  ADDR_W  index currently selected.
- STEP  output  1  one-cycle pulse on each scan advance.
- WRAP  output  1  one-cycle pulse when the scan index goes from OUT_W-1 to 0.
- ERR  output  1  sticky flag: a LOAD was attempted with ADDR >= OUT_W.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous, active-low, on RST_N.
- Reset values:
  - DEC is all inactive (0s, or 1s when ACTIVE_LOW=1).
  - CUR_ADDR = 0; STEP = 0; WRAP = 0; ERR = 0.
  - Prescaler = 0; state = IDLE.
- State machine (IDLE, DIRECT, SCAN):
  - IDLE → DIRECT when EN=1 and MODE=0.
  - IDLE → SCAN when EN=1 and MODE=1.
  - DIRECT ↔ SCAN follows MODE directly, with no pass through IDLE.
  - Any state → IDLE when EN=0. In IDLE, DEC is inactive and CUR_ADDR, prescaler and ERR hold their values.
- DIRECT mode:
  - A LOAD with ADDR < OUT_W latches ADDR into CUR_ADDR. DEC shows the matching one-hot the next cycle (1-cycle latency, LOAD edge to DEC).
  - A LOAD with ADDR >= OUT_W leaves CUR_ADDR and DEC unchanged and sets ERR the next cycle. ERR is cleared only by reset.
  - Without LOAD, DEC holds the decode of CUR_ADDR.
- SCAN mode:
  - Entering SCAN resets the prescaler to 0. The index starts from the current CUR_ADDR; it is not reset.
  - The prescaler counts 0..PRESCALE-1. On the terminal count, CUR_ADDR advances and STEP pulses in the same cycle that DEC changes.
  - The index advances to CUR_ADDR+1 mod OUT_W. It wraps at OUT_W-1 even when OUT_W < 2**ADDR_W; WRAP pulses together with STEP on that cycle.
  - PRESCALE=1 gives one step per cycle, with STEP held high continuously.
  - LOAD in SCAN mode is ignored, and ERR is not evaluated.
- Simultaneous and boundary events:
  - LOAD in the same cycle as MODE 0→1: the LOAD is ignored.
  - EN=0 in the same cycle as a scan terminal count: the step is suppressed and the prescaler holds.
  - Reset mid-scan: the next cycle shows the full reset state.
- Invariant: exactly one DEC bit is active whenever the state is not IDLE. DEC, STEP and WRAP are all registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: DEC_SCAN_BLANK_EN.
- Defined: in SCAN mode, each advance inserts one blanking cycle (DEC all inactive) before the new index is driven.
  - STEP pulses on the cycle the new output becomes active.
  - The blanking cycle is taken out of the PRESCALE period, so the step period is unchanged. Requires PRESCALE >= 2.
  - DIRECT mode is unaffected.
- Undefined: no blanking; the transition is direct, as described above.

Decomposition:
- Shared package dec_pkg:
  - Mode constants MODE_DIRECT=1'b0 and MODE_SCAN=1'b1.
  - State typedef dec_state_t with IDLE, DIRECT, SCAN.
  - Helper function onehot(idx, width).
- Sub-module tick_gen (parameter PRESCALE; ports CLK, RST_N, CLR, EN, TICK). It is reused for the prescaler.
- The decode itself stays in dec_scan_n.

Test Plan:
1. Reset with defaults: RST_N=0 for 2 cycles → DEC=16'h0000, CUR_ADDR=0, STEP=0, ERR=0.
2. DIRECT with EN=1, MODE=0, LOAD with ADDR=4'hA → DEC=16'h0400 one cycle later. Then LOAD ADDR=4'h3 → DEC=16'h0008.
3. Out-of-range LOAD with OUT_W=10, ADDR_W=4: LOAD ADDR=4'd12 → DEC unchanged, ERR=1 next cycle and stays 1 until reset.
4. SCAN with PRESCALE=4, OUT_W=16, starting at CUR_ADDR=0xE:
   - DEC goes 0x4000 → 0x8000 → 0x0001, each step 4 cycles apart.
   - WRAP pulses only on the step to 0x0001.
   - STEP count over 64 cycles = 16.
5. ACTIVE_LOW=1, DIRECT, LOAD ADDR=0 → DEC=16'hFFFE. Then EN=0 → DEC=16'hFFFF with CUR_ADDR held.
6. With DEC_SCAN_BLANK_EN defined and PRESCALE=4: each step shows exactly one all-inactive DEC cycle, and the step-to-step period stays 4 cycles.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared definitions for the dec_scan_n decoder: mode encodings, FSM state type
// and the one-hot helper used for the output decode.
package dec_pkg;

    localparam int MAX_ADDR_W = 6;
    localparam int MAX_OUT_W  = 64;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } dec_state_t;

    // Active-high one-hot of idx; an index at or beyond width yields all zeros.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_ADDR_W-1:0] idx,
                                                    input int width);
        logic [MAX_OUT_W-1:0] v;
        v = {MAX_OUT_W{1'b0}};
        if (int'(idx) < width) begin
            v[idx] = 1'b1;
        end else begin
            v = {MAX_OUT_W{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/dec_scan_n_tick_gen.sv
// Free-running prescaler: counts 0..PRESCALE-1 while enabled and flags the
// terminal count; CLR restarts the count from 0.
module tick_gen #(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_r;

    // Prescale counter; holds whenever the enable is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= (cnt_r == LAST_CNT) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en && !clr && (cnt_r == LAST_CNT);

endmodule

// File: rtl/dec_scan_n.sv
// Registered N-to-2^N one-hot decoder with DIRECT (latched address) and SCAN
// (prescaled auto-step) modes. Define DEC_SCAN_BLANK_EN for a blanking cycle per scan step.
module dec_scan_n #(
    parameter int ADDR_W     = 4,
    parameter int OUT_W      = 16,
    parameter int PRESCALE   = 16,
    parameter int ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic [ADDR_W-1:0] addr,
    output logic [OUT_W-1:0]  dec,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              step,
    output logic              wrap,
    output logic              err
);

    import dec_pkg::*;

    localparam logic [OUT_W-1:0]  INACTIVE = (ACTIVE_LOW != 0) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(OUT_W - 1);
    localparam logic [ADDR_W:0]   OUT_LIM  = (ADDR_W + 1)'(OUT_W);

    dec_state_t            state_r;
    dec_state_t            state_nxt_s;
    logic [ADDR_W-1:0]     cur_addr_r;
    logic [ADDR_W-1:0]     cur_nxt_s;
    logic [OUT_W-1:0]      dec_r;
    logic [OUT_W-1:0]      dec_nxt_s;
    logic                  step_r;
    logic                  wrap_r;
    logic                  err_r;
    logic                  step_nxt_s;
    logic                  wrap_nxt_s;
    logic                  err_nxt_s;
    logic                  run_s;
    logic                  clr_s;
    logic                  tick_s;
    logic                  adv_s;
    logic                  blank_s;
    logic                  load_s;
    logic                  in_range_s;
    logic [MAX_ADDR_W-1:0] idx_ext_s;
    logic [MAX_OUT_W-1:0]  hot_s;
    logic                  unused_hot_s;

    // The prescaler runs only while already scanning; entering SCAN restarts it.
    assign run_s = en && (mode == MODE_SCAN) && (state_r == SCAN);
    assign clr_s = en && (mode == MODE_SCAN) && (state_r != SCAN);

    tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .en    (run_s),
        .tick  (tick_s)
    );

`ifdef DEC_SCAN_BLANK_EN
    logic pend_r;

    // The terminal count blanks the outputs; the advance lands one cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_r <= 1'b0;
        end else begin
            pend_r <= tick_s;
        end
    end

    assign adv_s   = pend_r && run_s;
    assign blank_s = tick_s;
`else
    assign adv_s   = tick_s;
    assign blank_s = 1'b0;
`endif

    // Next-state logic: EN gates everything, otherwise MODE picks the state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE, DIRECT, SCAN: begin
                if (!en) begin
                    state_nxt_s = IDLE;
                end else if (mode == MODE_SCAN) begin
                    state_nxt_s = SCAN;
                end else begin
                    state_nxt_s = DIRECT;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Index, flag and decode computation for the next output registers.
    always_comb begin
        load_s     = en && (mode == MODE_DIRECT) && load;
        in_range_s = ({1'b0, addr} < OUT_LIM);
        cur_nxt_s  = cur_addr_r;
        step_nxt_s = 1'b0;
        wrap_nxt_s = 1'b0;
        err_nxt_s  = err_r;
        if (load_s && in_range_s) begin
            cur_nxt_s = addr;
        end else if (adv_s) begin
            cur_nxt_s  = (cur_addr_r == LAST_IDX) ? {ADDR_W{1'b0}} : cur_addr_r + ADDR_W'(1);
            step_nxt_s = 1'b1;
            wrap_nxt_s = (cur_addr_r == LAST_IDX);
        end else begin
            cur_nxt_s = cur_addr_r;
        end
        if (load_s && !in_range_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
        idx_ext_s                = {MAX_ADDR_W{1'b0}};
        idx_ext_s[ADDR_W-1:0]    = cur_nxt_s;
        hot_s                    = onehot(idx_ext_s, OUT_W);
        unused_hot_s             = ^hot_s;
        if ((state_nxt_s == IDLE) || blank_s) begin
            dec_nxt_s = INACTIVE;
        end else if (ACTIVE_LOW != 0) begin
            dec_nxt_s = ~hot_s[OUT_W-1:0];
        end else begin
            dec_nxt_s = hot_s[OUT_W-1:0];
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cur_addr_r <= {ADDR_W{1'b0}};
            dec_r      <= INACTIVE;
            step_r     <= 1'b0;
            wrap_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cur_addr_r <= cur_nxt_s;
            dec_r      <= dec_nxt_s;
            step_r     <= step_nxt_s;
            wrap_r     <= wrap_nxt_s;
            err_r      <= err_nxt_s;
        end
    end

    assign dec      = dec_r;
    assign cur_addr = cur_addr_r;
    assign step     = step_r;
    assign wrap     = wrap_r;
    assign err      = err_r;

endmodule
